// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wptr_full_ctrl
// Brief    : Async-FIFO write-domain pointer, registered full flag and sticky
//            overflow. Optional fill level / almost-full via WPTR_ALMOST_FULL_EN.
// Revision : 1.0  initial release
// ============================================================================
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  wclk,
    input  logic                  w_rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  woverflow,
    output logic [ADDR_WIDTH:0]   wfill,
    output logic                  walmost_full
);

    localparam int C_PTR_W = ADDR_WIDTH + 1;

    logic [C_PTR_W-1:0] wbin_q, wbin_d;
    logic [C_PTR_W-1:0] wptr_q, wptr_d;
    logic               wfull_q, wfull_d;
    logic               woverflow_q, woverflow_d;
    logic [C_PTR_W-1:0] w_rptr_full_cmp;

    // Full when write Gray equals read Gray with the two MSBs inverted.
    assign w_rptr_full_cmp = {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]};

    always_comb begin
        wen         = winc & ~wfull_q;
        wbin_d      = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
        wptr_d      = (wbin_d >> 1) ^ wbin_d;
        wfull_d     = (wptr_d == w_rptr_full_cmp);
        woverflow_d = woverflow_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk) begin
        if (!w_rst_n) begin
            wbin_q      <= '0;
            wptr_q      <= '0;
            wfull_q     <= 1'b0;
            woverflow_q <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr_q      <= wptr_d;
            wfull_q     <= wfull_d;
            woverflow_q <= woverflow_d;
        end
    end

    assign waddr     = wbin_q[ADDR_WIDTH-1:0];
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign woverflow = woverflow_q;

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [C_PTR_W-1:0] C_AF_THRESH = C_PTR_W'(AF_THRESH);

    logic [C_PTR_W-1:0] w_rbin_sync;
    logic [C_PTR_W-1:0] wfill_q, wfill_d;
    logic               walmost_full_q, walmost_full_d;

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi < C_PTR_W; gi++) begin : g_gray2bin
        assign w_rbin_sync[gi] = ^rptr_sync[ADDR_WIDTH:gi];
    end

    always_comb begin
        wfill_d        = wbin_d - w_rbin_sync;
        walmost_full_d = (wfill_d >= C_AF_THRESH);
    end

    always_ff @(posedge wclk) begin
        if (!w_rst_n) begin
            wfill_q        <= '0;
            walmost_full_q <= 1'b0;
        end else begin
            wfill_q        <= wfill_d;
            walmost_full_q <= walmost_full_d;
        end
    end

    assign wfill        = wfill_q;
    assign walmost_full = walmost_full_q;
`else
    logic [31:0] w_unused_af_thresh;
    assign w_unused_af_thresh = AF_THRESH;
    assign wfill        = '0;
    assign walmost_full = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wptr_full_ctrl
// Brief    : Randomized self-checking bench for wptr_full_ctrl against a
//            count-based FIFO occupancy model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wptr_full_ctrl;

    localparam int AW  = 8;
    localparam int DEP = 1 << AW;
    localparam int AFT = DEP - 4;

    logic          wclk = 1'b0;
    logic          w_rst_n;
    logic          winc;
    logic [AW:0]   rptr_sync;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          woverflow;
    logic [AW:0]   wfill;
    logic          walmost_full;

    wptr_full_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AFT)) u_dut (
        .wclk         (wclk),
        .w_rst_n      (w_rst_n),
        .winc         (winc),
        .rptr_sync    (rptr_sync),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .woverflow    (woverflow),
        .wfill        (wfill),
        .walmost_full (walmost_full)
    );

    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_err = 0;

    // Model: total writes accepted and total reads seen, as plain counts.
    int   m_w    = 0;
    int   m_r    = 0;
    bit   m_full = 0;
    bit   m_ovf  = 0;
    bit   m_ok   = 0;
    logic [AW:0] prev_wptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    // One clock: drive inputs, check combinational outputs, clock, check registers.
    task automatic cycle(input bit rst, input bit inc, input int rc);
        bit acc;
        int fill;
        w_rst_n   = ~rst;
        winc      = inc;
        rptr_sync = to_gray(rc);
        #2;
        acc = inc && !m_full;
        if (m_ok) begin
            chk("wen", {31'd0, wen}, {31'd0, acc});
            chk("waddr", {24'd0, waddr}, m_w % DEP);
        end
        prev_wptr = wptr;
        @(posedge wclk);
        #1;
        if (rst) begin
            m_w = 0; m_full = 0; m_ovf = 0; m_ok = 1;
            fill = 0;
        end else begin
            if (acc) m_w++;
            m_ovf  = m_ovf || (inc && m_full);
            fill   = (m_w - rc) % (2 * DEP);
            m_full = (fill == DEP);
            if (m_ok)
                chk("gray_step", $countones(wptr ^ prev_wptr), {31'd0, acc});
        end
        m_r = rc;
        if (m_ok) begin
            chk("wptr", {23'd0, wptr}, {23'd0, to_gray(m_w)});
            chk("wfull", {31'd0, wfull}, {31'd0, m_full});
            chk("woverflow", {31'd0, woverflow}, {31'd0, m_ovf});
`ifdef WPTR_ALMOST_FULL_EN
            chk("wfill", {23'd0, wfill}, fill);
            chk("walmost_full", {31'd0, walmost_full}, {31'd0, fill >= AFT});
`else
            chk("wfill", {23'd0, wfill}, 0);
            chk("walmost_full", {31'd0, walmost_full}, 0);
`endif
        end
    endtask

    initial begin
        int rc;
        int budget;
        bit msb_prev;
        w_rst_n = 1'b0; winc = 1'b0; rptr_sync = '0;
        @(posedge wclk); #1;

        // Reset held with a write requested: pointer must not advance.
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("rst_wptr", {23'd0, wptr}, 0);
        chk("rst_waddr", {24'd0, waddr}, 0);

        // Fill to full with no reads.
        for (int i = 0; i < DEP; i++) begin
            cycle(0, 1, 0);
            if (m_w == AFT - 1) begin
                chk("af_below", {31'd0, walmost_full}, 0);
            end
        end
        chk("full_wptr", {23'd0, wptr}, 32'h180);
        chk("full_flag", {31'd0, wfull}, 1);

        // Write while full is dropped and latches overflow.
        cycle(0, 1, 0);
        chk("ovf_wptr", {23'd0, wptr}, 32'h180);
        chk("ovf_flag", {31'd0, woverflow}, 1);

        // One read releases full; one more write re-fills.
        cycle(0, 0, 1);
        chk("release", {31'd0, wfull}, 0);
        cycle(0, 1, 1);
        chk("refull_wptr", {23'd0, wptr}, 32'h181);
        chk("refull_flag", {31'd0, wfull}, 1);
        chk("ovf_sticky", {31'd0, woverflow}, 1);

        // Wrap-around: reader trails by three, full must never assert.
        cycle(1, 0, 0);
        budget = 0;
        msb_prev = wptr[AW];
        while (m_w < 600 && budget < 4000) begin
            rc = (m_w > 3) ? m_w - 3 : 0;
            cycle(0, ($urandom % 4) != 0, rc);
            if (wptr[AW] != msb_prev) begin
                chk("msb_toggle_at", m_w % DEP, 0);
                msb_prev = wptr[AW];
            end
            budget++;
        end
        chk("wrap_count", m_w, 600);

        // Reset mid-burst.
        cycle(1, 0, 0);
        for (int i = 0; i < 100; i++) cycle(0, 1, 0);
        cycle(1, 0, 0);
        chk("midrst_wptr", {23'd0, wptr}, 0);
        chk("midrst_full", {31'd0, wfull}, 0);
        cycle(0, 1, 0);

        // Random traffic with a monotonic reader that stays within one depth.
        rc = 0;
        for (int i = 0; i < 1500; i++) begin
            int lo;
            lo = (m_w - DEP > rc) ? m_w - DEP : rc;
            if (($urandom % 3) == 0)
                rc = lo + int'($urandom_range(0, m_w - lo));
            else
                rc = lo;
            cycle(0, ($urandom % 4) != 0, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
